// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and default constants for the I2S receive-path
//                frame sequencer (controller state encoding, default widths,
//                counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Controller states: stopped, running, finishing the current frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_e;

  localparam int I2S_DATA_WIDTH = 32;
  localparam int I2S_CLK_DIV    = 4;
  localparam int I2S_SLOT_BITS  = 32;

  // Width of a counter holding 0..n-1; never narrower than one bit
  function automatic int i2s_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_clk_gen
//  Description : Generates the I2S bit clock (sck) and word select (ws) from
//                the system clock. Provides a one-cycle strobe in the clk
//                cycle that follows every sck falling edge (bit_cnt and ws
//                already hold their post-edge values then), and a frame_end
//                flag in the cycle whose closing edge takes ws from 1 to 0.
//                All state is held at zero while run is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV   = I2S_CLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  localparam int BIT_W    = i2s_cnt_width(SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             sck,
  output logic             ws,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             sck_fall,
  output logic             frame_end
);

  localparam int               c_DIV_W    = i2s_cnt_width(CLK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
  localparam logic [BIT_W-1:0]   c_BIT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]   c_BIT_ONE  = BIT_W'(1);

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_sck;
  logic               r_ws;
  logic               r_sck_fall;

  logic w_div_tc;
  logic w_fall;
  logic w_bit_wrap;

  assign w_div_tc   = (r_div_cnt == c_DIV_LAST);
  assign w_fall     = run & w_div_tc & r_sck;
  assign w_bit_wrap = (r_bit_cnt == c_BIT_LAST);

  // Divider, sck toggle, bit counter and ws toggle; cleared whenever stopped
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_sck      <= 1'b0;
      r_ws       <= 1'b0;
      r_sck_fall <= 1'b0;
    end else begin
      r_sck_fall <= w_fall;
      if (w_div_tc) begin
        r_div_cnt <= '0;
        r_sck     <= ~r_sck;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_ONE;
      end
      if (w_fall) begin
        if (w_bit_wrap) begin
          r_bit_cnt <= '0;
          r_ws      <= ~r_ws;
        end else begin
          r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
        end
      end
    end
  end

  assign sck       = r_sck;
  assign ws        = r_ws;
  assign bit_cnt   = r_bit_cnt;
  assign sck_fall  = r_sck_fall;
  assign frame_end = w_fall & w_bit_wrap & r_ws;

endmodule
`default_nettype wire

// File: rtl/i2s_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_frame_sequencer
//  Description : Master-side I2S receive controller. Owns sck/ws timing via
//                i2s_clk_gen, captures left/right words one bit after each
//                slot boundary, and offers stereo pairs on a valid/ready
//                interface with a sticky overrun flag.
//                Optional macro I2S_FRAME_COUNT_EN adds a 16-bit frame_count
//                output counting every pair load.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_sequencer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int CLK_DIV    = I2S_CLK_DIV,
  parameter int SLOT_BITS  = I2S_SLOT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  sck,
  output logic                  ws,
  input  logic [DATA_WIDTH-1:0] data_left_in,
  input  logic [DATA_WIDTH-1:0] data_right_in,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [DATA_WIDTH-1:0] pair_left,
  output logic [DATA_WIDTH-1:0] pair_right,
  output logic                  overrun,
`ifdef I2S_FRAME_COUNT_EN
  output logic [15:0]           frame_count,
`endif
  input  logic                  clear_overrun
);

  localparam int                 c_BIT_W   = i2s_cnt_width(SLOT_BITS);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE = c_BIT_W'(1);

  i2s_state_e r_state;
  i2s_state_e w_state_nxt;

  logic               w_run;
  logic               w_sck_fall;
  logic               w_frame_end;
  logic               w_ws;
  logic [c_BIT_W-1:0] w_bit_cnt;

  logic                  r_left_seen;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_pair_valid;
  logic [DATA_WIDTH-1:0] r_pair_left;
  logic [DATA_WIDTH-1:0] r_pair_right;
  logic                  r_overrun;

  logic w_cap_left;
  logic w_cap_right;
  logic w_load;
  logic w_xfer;

  assign w_run = (r_state != IDLE);

  i2s_clk_gen #(
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (w_run),
    .sck       (sck),
    .ws        (w_ws),
    .bit_cnt   (w_bit_cnt),
    .sck_fall  (w_sck_fall),
    .frame_end (w_frame_end)
  );

  assign ws = w_ws;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: DRAIN keeps the clocks alive until the frame closes, and a
  // re-enable there rejoins RUN without disturbing the running counters
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = DRAIN;
      DRAIN: begin
        if (enable)           w_state_nxt = RUN;
        else if (w_frame_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One-bit-delayed slot capture: strobe arrives with bit_cnt/ws post-edge
  assign w_cap_left  = w_sck_fall &  w_ws & (w_bit_cnt == c_BIT_ONE);
  assign w_cap_right = w_sck_fall & ~w_ws & (w_bit_cnt == c_BIT_ONE);
  assign w_load      = w_cap_right & r_left_seen;
  assign w_xfer      = r_pair_valid & pair_ready;

  // Left holding register; left_seen is dropped while stopped so a stale
  // left word never pairs with the first right word of a new run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_left_seen <= 1'b0;
    end else if (r_state == IDLE) begin
      r_left_seen <= 1'b0;
    end else if (w_cap_left) begin
      r_hold      <= data_left_in;
      r_left_seen <= 1'b1;
    end else if (w_cap_right) begin
      r_left_seen <= 1'b0;
    end
  end

  // Output pair and valid; a load always wins over a concurrent transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pair_valid <= 1'b0;
      r_pair_left  <= '0;
      r_pair_right <= '0;
    end else if (w_load) begin
      r_pair_valid <= 1'b1;
      r_pair_left  <= r_hold;
      r_pair_right <= data_right_in;
    end else if (w_xfer) begin
      r_pair_valid <= 1'b0;
    end
  end

  // Sticky overrun: set on overwrite of an unaccepted pair, set beats clear
  always_ff @(posedge clk) begin
    if (!rst_n)                                  r_overrun <= 1'b0;
    else if (w_load & r_pair_valid & ~pair_ready) r_overrun <= 1'b1;
    else if (clear_overrun)                      r_overrun <= 1'b0;
  end

  assign pair_valid = r_pair_valid;
  assign pair_left  = r_pair_left;
  assign pair_right = r_pair_right;
  assign overrun    = r_overrun;

`ifdef I2S_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Count every pair load, overwrites included; wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n)      r_frame_count <= 16'd0;
    else if (w_load) r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_frame_sequencer
//  Description : Directed self-checking bench for i2s_frame_sequencer with
//                CLK_DIV=4, SLOT_BITS=32. Cycle t=0 is the first clk cycle
//                in RUN; sck falls into cycle 8n, ws toggles every 256 clk,
//                right captures sit at 512k+8, left captures at 512k+264,
//                so the first pair is visible at t=521.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sck;
  logic        ws;
  logic [31:0] data_left_in;
  logic [31:0] data_right_in;
  logic        pair_valid;
  logic        pair_ready;
  logic [31:0] pair_left;
  logic [31:0] pair_right;
  logic        overrun;
  logic        clear_overrun;
`ifdef I2S_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  i2s_frame_sequencer #(
    .DATA_WIDTH (32),
    .CLK_DIV    (4),
    .SLOT_BITS  (32)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sck           (sck),
    .ws            (ws),
    .data_left_in  (data_left_in),
    .data_right_in (data_right_in),
    .pair_valid    (pair_valid),
    .pair_ready    (pair_ready),
    .pair_left     (pair_left),
    .pair_right    (pair_right),
    .overrun       (overrun),
`ifdef I2S_FRAME_COUNT_EN
    .frame_count   (frame_count),
`endif
    .clear_overrun (clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int t       = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic go_to(input int target);
    while (t < target) tick();
  endtask

  // Raise enable; the next sample point is RUN cycle 0
  task automatic start_run();
    enable = 1'b1;
    @(negedge clk);
    t = 0;
  endtask

  int          sck_rise1, sck_fall1, ws_rise1, ws_rise2, ws_fall1;
  int          pv1, pv2, pv_cycles, toggles;
  logic [31:0] pl1, pr1;
  logic        prev_sck, prev_ws, quiet;

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    pair_ready    = 1'b1;
    clear_overrun = 1'b0;
    data_left_in  = '0;
    data_right_in = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sck",     sck,        1'b0);
    chk("rst_ws",      ws,         1'b0);
    chk("rst_valid",   pair_valid, 1'b0);
    chk("rst_left",    pair_left,  32'h0);
    chk("rst_right",   pair_right, 32'h0);
    chk("rst_overrun", overrun,    1'b0);

    // Idle with enable low: bus and flags stay quiet
    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (100) begin
      @(negedge clk);
      quiet = quiet | sck | ws | pair_valid | overrun;
    end
    chk("idle_quiet", quiet, 1'b0);

    // Free-running timing and first pairs with pair_ready held high
    data_left_in  = 32'hDEADBEEF;
    data_right_in = 32'h12345678;
    start_run();
    chk("run_entry_sck", sck, 1'b0);
    sck_rise1 = -1; sck_fall1 = -1; ws_rise1 = -1; ws_rise2 = -1; ws_fall1 = -1;
    pv1 = -1; pv2 = -1; pv_cycles = 0; pl1 = '0; pr1 = '0;
    prev_sck = sck; prev_ws = ws;
    while (t < 1100) begin
      tick();
      if (sck && !prev_sck && sck_rise1 < 0) sck_rise1 = t;
      if (!sck && prev_sck && sck_fall1 < 0) sck_fall1 = t;
      if (ws && !prev_ws) begin
        if (ws_rise1 < 0)      ws_rise1 = t;
        else if (ws_rise2 < 0) ws_rise2 = t;
      end
      if (!ws && prev_ws && ws_fall1 < 0) ws_fall1 = t;
      if (pair_valid) begin
        pv_cycles++;
        if (pv1 < 0) begin
          pv1 = t; pl1 = pair_left; pr1 = pair_right;
        end else if (pv2 < 0) begin
          pv2 = t;
        end
      end
      prev_sck = sck; prev_ws = ws;
    end
    chk("sck_first_rise", sck_rise1, 4);
    chk("sck_first_fall", sck_fall1, 8);
    chk("ws_first_rise",  ws_rise1,  256);
    chk("ws_first_fall",  ws_fall1,  512);
    chk("ws_second_rise", ws_rise2,  768);
    chk("pv_first",       pv1,       521);
    chk("pv_second",      pv2,       1033);
    chk("pv_cycles",      pv_cycles, 2);
    chk("pv_first_left",  pl1,       32'hDEADBEEF);
    chk("pv_first_right", pr1,       32'h12345678);
    chk("run_overrun",    overrun,   1'b0);

    // Back-pressure across three loads (1544, 2056, 2568)
    pair_ready = 1'b0;
    data_left_in = 32'hA1A10001; data_right_in = 32'hB1B10001;
    go_to(1550);
    chk("bp1_valid",   pair_valid, 1'b1);
    chk("bp1_overrun", overrun,    1'b0);
    chk("bp1_left",    pair_left,  32'hA1A10001);
    chk("bp1_right",   pair_right, 32'hB1B10001);
    go_to(1600);
    data_left_in = 32'hA2A20002; data_right_in = 32'hB2B20002;
    go_to(2060);
    chk("bp2_overrun", overrun,    1'b1);
    chk("bp2_valid",   pair_valid, 1'b1);
    chk("bp2_left",    pair_left,  32'hA2A20002);
    chk("bp2_right",   pair_right, 32'hB2B20002);
    go_to(2100);
    data_left_in = 32'hA3A30003; data_right_in = 32'hB3B30003;
    go_to(2570);
    chk("bp3_left",    pair_left,  32'hA3A30003);
    chk("bp3_right",   pair_right, 32'hB3B30003);
    chk("bp3_overrun", overrun,    1'b1);
    go_to(2580);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("clr_overrun", overrun,    1'b0);
    chk("clr_valid",   pair_valid, 1'b1);

    // Ready exactly on the load cycle (3080): old accepted, new loaded
    go_to(2600);
    data_left_in = 32'hA4A40004; data_right_in = 32'hB4B40004;
    go_to(3080);
    pair_ready = 1'b1;
    tick();
    chk("coinc_valid",   pair_valid, 1'b1);
    chk("coinc_overrun", overrun,    1'b0);
    chk("coinc_left",    pair_left,  32'hA4A40004);
    chk("coinc_right",   pair_right, 32'hB4B40004);
    tick();
    chk("coinc_drop", pair_valid, 1'b0);

    // Drain: enable drops at bit_cnt=5 of the ws=0 slot starting at 3584
    go_to(3624);
    enable = 1'b0;
    toggles = 0;
    prev_sck = sck;
    while (t < 4095) begin
      tick();
      if (sck !== prev_sck) toggles++;
      prev_sck = sck;
    end
    chk("drain_toggles", toggles, 117);
    chk("drain_ws_hi",   ws,      1'b1);
    tick();
    chk("drain_end_sck", sck, 1'b0);
    chk("drain_end_ws",  ws,  1'b0);
    quiet = 1'b0;
    while (t < 4200) begin
      tick();
      quiet = quiet | sck | ws;
    end
    chk("drain_idle_quiet", quiet, 1'b0);
`ifdef I2S_FRAME_COUNT_EN
    chk("frame_count", frame_count, 16'd7);
`endif

    // Restart: stale left is not paired; set-beats-clear; mid-slot reset
    pair_ready    = 1'b0;
    data_left_in  = 32'hDEADBEEF;
    data_right_in = 32'h12345678;
    start_run();
    go_to(300);
    chk("restart_no_stale", pair_valid, 1'b0);
    go_to(521);
    chk("restart_valid", pair_valid, 1'b1);
    chk("restart_left",  pair_left,  32'hDEADBEEF);
    go_to(1032);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("set_beats_clear", overrun, 1'b1);
    go_to(1100);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sck",     sck,        1'b0);
    chk("mid_rst_ws",      ws,         1'b0);
    chk("mid_rst_valid",   pair_valid, 1'b0);
    chk("mid_rst_left",    pair_left,  32'h0);
    chk("mid_rst_right",   pair_right, 32'h0);
    chk("mid_rst_overrun", overrun,    1'b0);
`ifdef I2S_FRAME_COUNT_EN
    chk("mid_rst_count", frame_count, 16'd0);
`endif
    rst_n = 1'b1;
    tick();
    t = 0;
    go_to(520);
    chk("post_rst_no_pair", pair_valid, 1'b0);
    tick();
    chk("post_rst_pair", pair_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
